// File: rtl/acc_sr_nch.sv
// Multi-channel bit-serial accumulator: weights each incoming bit-plane partial
// sum by 2^k (MSB plane negated in signed mode) and sums per channel.
module acc_sr_nch #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int N  = 4,
  localparam int PW = $clog2(M) + 2,
  localparam int RW = $clog2(M) + Pa + 2,
  localparam int CW = $clog2(Pa + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*PW-1:0] in_ps,
  input  logic [CW-1:0]   prec,
  input  logic            signed_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*RW-1:0] out_res
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] p_reg;
  logic          sgn_reg;

  logic          accept;
  logic [CW-1:0] prec_eff;
  logic [CW-1:0] p_cur;
  logic [CW-1:0] k_cur;
  logic          sgn_cur;
  logic          last_beat;
  logic          neg;

  assign in_ready  = (state_reg != HOLD);
  assign out_valid = (state_reg == HOLD);
  assign accept    = in_valid && in_ready;

  // The first beat is weighted with the precision/mode presented alongside it,
  // since the latched copies are only written on that same edge.
  always_comb begin
    prec_eff = prec;
    if (prec == '0 || prec > CW'(Pa)) prec_eff = CW'(Pa);
    p_cur     = (state_reg == IDLE) ? prec_eff : p_reg;
    sgn_cur   = (state_reg == IDLE) ? signed_mode : sgn_reg;
    k_cur     = (state_reg == IDLE) ? '0 : cnt_reg;
    last_beat = (k_cur == p_cur - CW'(1));
    neg       = sgn_cur && last_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      p_reg     <= '0;
      sgn_reg   <= 1'b0;
    end else if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            p_reg     <= prec_eff;
            sgn_reg   <= signed_mode;
            cnt_reg   <= CW'(1);
            state_reg <= last_beat ? HOLD : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            cnt_reg <= cnt_reg + CW'(1);
            if (last_beat) state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] shifted;
    logic signed [RW-1:0] term;
    logic signed [RW-1:0] acc_reg;

    assign ext     = {{(RW-PW){in_ps[gi*PW+PW-1]}}, in_ps[gi*PW +: PW]};
    assign shifted = ext <<< k_cur;
    assign term    = neg ? -shifted : shifted;

    // The first beat overwrites rather than adds, so no separate clear between operations.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_reg <= '0;
      end else if (clr) begin
        acc_reg <= '0;
      end else if (accept) begin
        acc_reg <= (state_reg == IDLE) ? term : acc_reg + term;
      end
    end

    assign out_res[gi*RW +: RW] = acc_reg;
  end

endmodule

// File: tb/tb_acc_sr_nch.sv
// Randomized and directed bench for acc_sr_nch against an arithmetic reference model.
module tb_acc_sr_nch;
  localparam int M  = 16;
  localparam int PA = 8;
  localparam int N  = 4;
  localparam int PW = 6;
  localparam int RW = 14;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*PW-1:0] in_ps = '0;
  logic [CW-1:0]   prec = '0;
  logic            signed_mode = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N*RW-1:0] out_res;

  int n_tests = 0;
  int n_fail  = 0;
  int ps_mem[N][PA];
  int exp_res[N];
  int last_res[N];

  acc_sr_nch #(.M(M), .Pa(PA), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_ps(in_ps), .prec(prec), .signed_mode(signed_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_res(out_res)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  // Reference: R = sum_k ps_k * 2^k, with the top plane negated in signed mode.
  function automatic int model(input int c, input int p, input bit sgn);
    int sum = 0;
    for (int k = 0; k < p; k++) begin
      int w = 1 << k;
      if (sgn && k == p - 1) w = -w;
      sum += ps_mem[c][k] * w;
    end
    return sum;
  endfunction

  function automatic logic [N*PW-1:0] pack(input int k);
    logic [N*PW-1:0] v = '0;
    for (int c = 0; c < N; c++) v[c*PW +: PW] = PW'(ps_mem[c][k]);
    return v;
  endfunction

  function automatic int res_of(input int c);
    logic signed [RW-1:0] r;
    r = out_res[c*RW +: RW];
    return int'(r);
  endfunction

  task automatic fill_random();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < PA; k++) ps_mem[c][k] = int'($urandom_range(63)) - 32;
  endtask

  task automatic chk_res(input string tag);
    for (int c = 0; c < N; c++) chk($sformatf("%s:ch%0d", tag, c), res_of(c), exp_res[c]);
  endtask

  task automatic do_op(input int prec_in, input bit sgn, input int gap_pct,
                       input int hold_wait, input string tag);
    int p;
    int k;
    p = (prec_in == 0 || prec_in > PA) ? PA : prec_in;
    for (int c = 0; c < N; c++) exp_res[c] = model(c, p, sgn);
    k = 0;
    while (k < p) begin
      @(negedge clk);
      chk({tag, ":in_ready"}, int'(in_ready), 1);
      chk({tag, ":early_valid"}, int'(out_valid), 0);
      if (k > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_ps    = N*PW'($urandom);
      end else begin
        in_valid    = 1'b1;
        in_ps       = pack(k);
        prec        = (k == 0) ? CW'(prec_in) : CW'($urandom);
        signed_mode = (k == 0) ? sgn : 1'($urandom);
        k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ":out_valid"}, int'(out_valid), 1);
    chk({tag, ":hold_ready"}, int'(in_ready), 0);
    chk_res(tag);
    for (int c = 0; c < N; c++) last_res[c] = res_of(c);
    for (int i = 0; i < hold_wait; i++) begin
      in_valid = 1'($urandom);
      in_ps    = N*PW'($urandom);
      @(negedge clk);
      chk({tag, ":bp_valid"}, int'(out_valid), 1);
      chk({tag, ":bp_ready"}, int'(in_ready), 0);
      chk_res({tag, ":bp"});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ":done_valid"}, int'(out_valid), 0);
    chk({tag, ":done_ready"}, int'(in_ready), 1);
  endtask

  task automatic drive_beats(input int nb, input int prec_in, input bit sgn);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_ps       = pack(k);
      prec        = CW'(prec_in);
      signed_mode = sgn;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":in_ready"}, int'(in_ready), 1);
    chk({tag, ":out_valid"}, int'(out_valid), 0);
    for (int c = 0; c < N; c++) chk($sformatf("%s:res%0d", tag, c), res_of(c), 0);
  endtask

  initial begin
    #3;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic unsigned / signed, prec=4
    fill_random();
    ps_mem[0][0] = 3; ps_mem[0][1] = 5; ps_mem[0][2] = -2; ps_mem[0][3] = 1;
    do_op(4, 1'b0, 0, 0, "uns4");
    chk("uns4_const", last_res[0], 13);
    do_op(4, 1'b1, 0, 0, "sgn4");
    chk("sgn4_const", last_res[0], -3);

    // Extremes, prec=8
    for (int c = 0; c < N; c++) for (int k = 0; k < PA; k++) ps_mem[c][k] = -32;
    do_op(8, 1'b0, 0, 0, "ext_uns");
    chk("ext_uns_const", last_res[3], -8160);
    for (int c = 0; c < N; c++) ps_mem[c][7] = 31;
    do_op(8, 1'b1, 0, 0, "ext_sgn");
    chk("ext_sgn_const", last_res[2], -8032);

    // prec=1 signed goes straight to HOLD; prec=0 means full precision
    for (int c = 0; c < N; c++) ps_mem[c][0] = -32;
    do_op(1, 1'b1, 0, 0, "p1_sgn");
    chk("p1_sgn_const", last_res[1], 32);
    fill_random();
    do_op(0, 1'b0, 0, 0, "p0");

    // Stalls, then long backpressure
    do_op(8, 1'b1, 50, 0, "stall");
    do_op(5, 1'b0, 0, 10, "bp10");

    // Clear after beat 2 of a prec=6 op, with a beat presented alongside clr
    fill_random();
    drive_beats(3, 6, 1'b0);
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_ps    = pack(3);
    @(negedge clk);
    clr      = 1'b0;
    in_valid = 1'b0;
    chk_reset_outputs("clr");
    fill_random();
    do_op(2, 1'b1, 0, 0, "after_clr");

    // Asynchronous reset mid-ACC
    fill_random();
    drive_beats(3, 8, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(3, 1'b0, 0, 0, "after_rst");

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      fill_random();
      do_op(int'($urandom_range(15)), 1'($urandom), 30, int'($urandom_range(3)),
            $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_sr_nch.md
# acc_sr_nch

Multi-channel, runtime-precision bit-serial accumulator for the SMAC dot-product datapath. Each beat delivers one partial sum per channel for a single activation bit plane, LSB plane first. The block weights each plane by its power of two and accumulates in an internal adder; in signed mode the MSB plane is subtracted. It replaces the single-channel, fixed-precision accumulator shift register and adds per-channel vectors, runtime precision, a signed/unsigned mode and valid/ready handshakes on both sides.

## Interface
- M, 16: number of products summed per partial sum.
- Pa, 8: maximum activation precision in bits; Pa >= 1.
- N, 4: number of channels.
- Derived widths, fixed in the block:
  - PW = $clog2(M)+2: partial-sum width, two's complement.
  - RW = $clog2(M)+Pa+2: result width, two's complement.
  - CW = $clog2(Pa+1): width of the `prec` and plane-counter fields.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear, abandons the current operation.
- in_valid  in  1  a bit-plane beat is present on in_ps.
- in_ready  out  1  the block accepts a beat this cycle.
- in_ps  in  N*PW  per-channel partial sums; channel c occupies bits [c*PW +: PW].
- prec  in  CW  activation precision, sampled on the first beat only.
- signed_mode  in  1  1 = activation is two's complement; sampled on the first beat only.
- out_valid  out  1  out_res holds a finished result.
- out_ready  in  1  the consumer takes the result.
- out_res  out  N*RW  per-channel results; channel c occupies bits [c*RW +: RW].

## Operation
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted when in_valid && in_ready. Beats are numbered k = 0, 1, ... within one operation.
- IDLE with an accepted beat:
  - Latch P = prec. If prec is 0 or greater than Pa, P = Pa.
  - Latch signed_mode.
  - For every channel, acc = sext(ps)*w0, where wk is defined below.
  - Set the plane counter to 1.
  - Go to HOLD if P == 1, otherwise go to ACC.
- ACC with an accepted beat k:
  - acc += sext(ps)*wk for every channel; the counter increments.
  - When k == P-1, go to HOLD.
- Plane weight:
  - wk = 2^k.
  - Exception: when signed_mode is latched and k == P-1, wk = -2^(P-1).
- Result per channel: R = sum over k of ps_k*wk. R fits in RW bits for every legal input, so no saturation or wrap is needed.
- HOLD:
  - out_res and out_valid stay stable until out_ready is sampled high.
  - On that edge go to IDLE and clear out_valid. out_res keeps its value until the next result is written.
- ACC with in_valid low: state, counter and accumulators hold (stall); the idle gap between beats has no limit.
- prec and signed_mode are ignored on every beat after the first.
- clr:
  - Priority below rst_n and above all other activity.
  - On the edge: go to IDLE, zero the accumulators, the counter and out_res, and deassert out_valid.
  - A beat presented in the same cycle is dropped.
- Result storage: the accumulator registers drive out_res directly. No extra output pipeline stage.

## Timing
- Reset values:
  - state = IDLE, so in_ready = 1 while reset is asserted.
  - out_valid = 0.
  - out_res = 0.
  - counter = 0; latched prec and signed_mode = 0.
- Asynchronous reset mid-operation discards all progress immediately. No result is emitted.
- Latency: out_valid rises on the clock edge that accepts the last beat (beat P-1). The result is visible in the following cycle.
- Throughput: one operation every P+1 cycles at full rate. HOLD always takes at least one cycle with in_ready=0, so there is no back-to-back overlap.
- in_ready and out_valid are decoded from the state register only. They have no combinational path from in_valid or out_ready.
- The block does not assume in_valid stays high while in_ready is low.

## Test plan
- Unsigned, M=16, Pa=8, N=4, prec=4, ch0 ps = 3, 5, -2, 1 over four contiguous beats -> out_valid rises the cycle after beat 3; ch0 out_res = 13.
- Same stimulus with signed_mode=1 -> ch0 = -3.
- Extremes, prec=8:
  - unsigned, all channels ps = -32 on every beat -> -8160 on every channel.
  - signed, ps = -32 on beats 0-6 and 31 on beat 7 -> -8032.
- prec edge cases:
  - prec=1, signed, ps = -32 -> 32, with HOLD entered directly from IDLE.
  - prec=0 -> behaves as prec=8 (8 beats are consumed).
- Stalls and backpressure:
  - Random in_valid gaps inside ACC -> same result as the contiguous run.
  - out_ready held low for 10 cycles -> out_res stable and in_ready=0 throughout; the next operation starts only after the handshake.
- Clear and reset mid-operation:
  - clr after beat 2 of prec=6 -> IDLE and out_res=0 next cycle; a new 2-beat operation then gives the correct result.
  - rst_n pulsed mid-ACC -> all outputs at reset values without waiting for a clock edge.
